// File: rtl/router_pkg.sv
// rtl/router_pkg.sv - shared router constants and header decode helper
package router_pkg;

    localparam int DATA_W      = 8;
    localparam int FIFO_DEPTH  = 16;
    localparam int FIFO_ADDR_W = 4;

    // Payload length field inside the header byte
    localparam int LEN_MSB = 7;
    localparam int LEN_LSB = 2;

    localparam int PKT_CNT_W = 7;

    // Bytes still to come after a header: payload length plus the parity byte
    function automatic logic [PKT_CNT_W-1:0] hdr_pkt_cnt(input logic [DATA_W-1:0] hdr);
        return PKT_CNT_W'(hdr[LEN_MSB:LEN_LSB]) + PKT_CNT_W'(1);
    endfunction

endpackage

// File: rtl/router_fifo.sv
// rtl/router_fifo.sv - per-destination packet buffer with header-aware read counter
//
// Ports:
//   clk       sole clock, rising edge
//   rst       synchronous active-high reset
//   sft_rst   synchronous soft reset from the synchronizer
//   wr_en     write strobe
//   rd_en     read strobe from the destination port
//   lfd_state tags the byte being written as a packet header
//   d_in      write data
//   d_out     registered read data
//   full      no free entry
//   empty     no stored entry
module router_fifo #(
    parameter int DATA_W = router_pkg::DATA_W,
    parameter int DEPTH  = router_pkg::FIFO_DEPTH,
    parameter int ADDR_W = router_pkg::FIFO_ADDR_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              sft_rst,
    input  logic              wr_en,
    input  logic              rd_en,
    input  logic              lfd_state,
    input  logic [DATA_W-1:0] d_in,
    output logic [DATA_W-1:0] d_out,
    output logic              full,
    output logic              empty
);

    localparam int CNT_W = router_pkg::PKT_CNT_W;

    logic [ADDR_W:0]   wr_ptr_q, wr_ptr_d;
    logic [ADDR_W:0]   rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]  pkt_cnt_q, pkt_cnt_d;
    logic [DATA_W-1:0] d_out_q, d_out_d;

    // Bit DATA_W of each entry is the header tag
    logic [DATA_W:0]   mem_q [DEPTH];

    logic              wr_fire;
    logic              rd_fire;
    logic              clear;
    logic [DATA_W:0]   rd_entry;

    // MSB of each pointer is a wrap bit, so equal addresses mean either
    // empty (same lap) or full (writer one lap ahead).
    assign empty = (wr_ptr_q == rd_ptr_q);
    assign full  = (wr_ptr_q[ADDR_W-1:0] == rd_ptr_q[ADDR_W-1:0]) &&
                   (wr_ptr_q[ADDR_W] != rd_ptr_q[ADDR_W]);

    assign wr_fire  = wr_en && !full;
    assign rd_fire  = rd_en && !empty;
    assign clear    = rst || sft_rst;
    assign rd_entry = mem_q[rd_ptr_q[ADDR_W-1:0]];

    always_comb begin
        wr_ptr_d  = wr_ptr_q;
        rd_ptr_d  = rd_ptr_q;
        pkt_cnt_d = pkt_cnt_q;
        d_out_d   = d_out_q;

        if (wr_fire) begin
            wr_ptr_d = wr_ptr_q + (ADDR_W+1)'(1);
        end

        if (rd_fire) begin
            rd_ptr_d = rd_ptr_q + (ADDR_W+1)'(1);
            d_out_d  = rd_entry[DATA_W-1:0];
            if (rd_entry[DATA_W]) begin
                pkt_cnt_d = router_pkg::hdr_pkt_cnt(rd_entry[DATA_W-1:0]);
            end else if (pkt_cnt_q != '0) begin
                pkt_cnt_d = pkt_cnt_q - CNT_W'(1);
            end
        end else if (pkt_cnt_q == '0) begin
            // Between packets the port sees zeros rather than a stale byte
            d_out_d = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (clear) begin
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            pkt_cnt_q <= '0;
            d_out_q   <= '0;
        end else begin
            wr_ptr_q  <= wr_ptr_d;
            rd_ptr_q  <= rd_ptr_d;
            pkt_cnt_q <= pkt_cnt_d;
            d_out_q   <= d_out_d;
        end
    end

    // Storage is never cleared; a write coinciding with either reset is dropped
    always_ff @(posedge clk) begin
        if (wr_fire && !clear) begin
            mem_q[wr_ptr_q[ADDR_W-1:0]] <= {lfd_state, d_in};
        end
    end

    assign d_out = d_out_q;

endmodule

// File: tb/tb_router_fifo.sv
// tb/tb_router_fifo.sv - directed self-checking bench for router_fifo
module tb_router_fifo;

    logic       clk;
    logic       rst;
    logic       sft_rst;
    logic       wr_en;
    logic       rd_en;
    logic       lfd_state;
    logic [7:0] d_in;
    logic [7:0] d_out;
    logic       full;
    logic       empty;

    int checks = 0;
    int errors = 0;

    router_fifo dut (
        .clk       (clk),
        .rst       (rst),
        .sft_rst   (sft_rst),
        .wr_en     (wr_en),
        .rd_en     (rd_en),
        .lfd_state (lfd_state),
        .d_in      (d_in),
        .d_out     (d_out),
        .full      (full),
        .empty     (empty)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [8:0] obs, input logic [8:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic cyc(input logic w, input logic r, input logic l, input logic [7:0] d);
        wr_en     = w;
        rd_en     = r;
        lfd_state = l;
        d_in      = d;
        @(posedge clk);
        #1;
    endtask

    function automatic logic [7:0] wdat(input int k);
        return 8'((k * 7 + 3) & 255);
    endfunction

    initial begin
        rst = 1'b1; sft_rst = 1'b0;

        // Reset held two cycles with a write pending
        cyc(1'b1, 1'b0, 1'b0, 8'h77);
        cyc(1'b1, 1'b0, 1'b0, 8'h77);
        check("rst_empty", empty, 1);
        check("rst_full",  full,  0);
        check("rst_dout",  d_out, 0);
        rst = 1'b0;
        cyc(1'b0, 1'b0, 1'b0, 8'h00);
        check("rst_nothing_stored", empty, 1);

        // Basic packet: header 0D -> 3 payload bytes plus parity
        cyc(1'b1, 1'b0, 1'b1, 8'h0D);
        check("pkt_empty_after_wr", empty, 0);
        cyc(1'b1, 1'b0, 1'b0, 8'hA1);
        cyc(1'b1, 1'b0, 1'b0, 8'hA2);
        cyc(1'b1, 1'b0, 1'b0, 8'hA3);
        cyc(1'b1, 1'b0, 1'b0, 8'h5F);
        cyc(1'b0, 1'b1, 1'b0, 8'h00); check("pkt_rd0", d_out, 9'h0D);
        cyc(1'b0, 1'b1, 1'b0, 8'h00); check("pkt_rd1", d_out, 9'hA1);
        cyc(1'b0, 1'b1, 1'b0, 8'h00); check("pkt_rd2", d_out, 9'hA2);
        cyc(1'b0, 1'b1, 1'b0, 8'h00); check("pkt_rd3", d_out, 9'hA3);
        cyc(1'b0, 1'b1, 1'b0, 8'h00); check("pkt_rd4", d_out, 9'h5F);
        check("pkt_empty", empty, 1);
        cyc(1'b0, 1'b0, 1'b0, 8'h00); check("pkt_idle_zero", d_out, 0);

        // Short packet with a gap mid-packet: d_out holds while count is nonzero
        cyc(1'b1, 1'b0, 1'b1, 8'h04);
        cyc(1'b1, 1'b0, 1'b0, 8'h11);
        cyc(1'b1, 1'b0, 1'b0, 8'h22);
        cyc(1'b0, 1'b1, 1'b0, 8'h00); check("gap_hdr", d_out, 9'h04);
        cyc(1'b0, 1'b0, 1'b0, 8'h00); check("gap_hold", d_out, 9'h04);
        cyc(1'b0, 1'b1, 1'b0, 8'h00); check("gap_pay", d_out, 9'h11);
        cyc(1'b0, 1'b1, 1'b0, 8'h00); check("gap_par", d_out, 9'h22);
        cyc(1'b0, 1'b0, 1'b0, 8'h00); check("gap_idle_zero", d_out, 0);

        // Read while empty is ignored
        cyc(1'b0, 1'b1, 1'b0, 8'h00);
        check("rd_empty_dout",  d_out, 0);
        check("rd_empty_empty", empty, 1);

        // Fill and overflow
        for (int i = 0; i < 16; i++) begin
            cyc(1'b1, 1'b0, 1'b0, 8'(8'h30 + i));
            if (i == 14) check("fill_not_full_15", full, 0);
        end
        check("fill_full",  full,  1);
        check("fill_empty", empty, 0);
        cyc(1'b1, 1'b0, 1'b0, 8'hFF);
        check("ovf_still_full", full, 1);

        // Read+write at full: only the read happens
        cyc(1'b1, 1'b1, 1'b0, 8'hEE);
        check("rw_full_dout", d_out, 9'h30);
        check("rw_full_full", full, 0);
        // Read+write when not full: both happen, occupancy stays 15
        cyc(1'b1, 1'b1, 1'b0, 8'hEE);
        check("rw_mid_dout", d_out, 9'h31);
        check("rw_mid_full", full, 0);
        cyc(1'b1, 1'b0, 1'b0, 8'hDD);
        check("rw_refull", full, 1);
        for (int i = 2; i < 16; i++) begin
            cyc(1'b0, 1'b1, 1'b0, 8'h00);
            check("drain", d_out, 9'(8'h30 + i));
        end
        cyc(1'b0, 1'b1, 1'b0, 8'h00); check("drain_ee", d_out, 9'hEE);
        cyc(1'b0, 1'b1, 1'b0, 8'h00); check("drain_dd", d_out, 9'hDD);
        check("drain_empty", empty, 1);

        // Read+write at empty: only the write happens
        cyc(1'b1, 1'b1, 1'b0, 8'h5A);
        check("rw_empty_empty", empty, 0);
        check("rw_empty_dout",  d_out, 0);
        cyc(1'b0, 1'b1, 1'b0, 8'h00);
        check("rw_empty_rd", d_out, 9'h5A);
        check("rw_empty_after", empty, 1);

        // Wrap-around stream of 40 bytes at occupancy 8
        for (int k = 0; k < 8; k++) begin
            cyc(1'b1, 1'b0, 1'b0, wdat(k));
        end
        for (int k = 8; k < 40; k++) begin
            cyc(1'b1, 1'b1, 1'b0, wdat(k));
            check("wrap_data",  d_out, 9'(wdat(k - 8)));
            check("wrap_full",  full,  0);
            check("wrap_empty", empty, 0);
        end
        for (int k = 32; k < 40; k++) begin
            cyc(1'b0, 1'b1, 1'b0, 8'h00);
            check("wrap_tail", d_out, 9'(wdat(k)));
        end
        check("wrap_end_empty", empty, 1);

        // Soft reset mid-read
        cyc(1'b1, 1'b0, 1'b1, 8'h10);
        for (int i = 1; i < 6; i++) begin
            cyc(1'b1, 1'b0, 1'b0, 8'(8'hB0 + i));
        end
        cyc(1'b0, 1'b1, 1'b0, 8'h00); check("srst_rd0", d_out, 9'h10);
        cyc(1'b0, 1'b1, 1'b0, 8'h00); check("srst_rd1", d_out, 9'hB1);
        sft_rst = 1'b1;
        cyc(1'b1, 1'b1, 1'b0, 8'hCC);
        sft_rst = 1'b0;
        check("srst_empty", empty, 1);
        check("srst_dout",  d_out, 0);
        check("srst_full",  full,  0);
        cyc(1'b0, 1'b0, 1'b0, 8'h00);
        check("srst_wr_dropped", empty, 1);
        check("srst_idle_dout",  d_out, 0);

        // Held soft reset keeps the FIFO empty
        sft_rst = 1'b1;
        cyc(1'b1, 1'b0, 1'b0, 8'hAA);
        check("srst_hold0", empty, 1);
        cyc(1'b1, 1'b0, 1'b0, 8'hAB);
        check("srst_hold1", empty, 1);
        sft_rst = 1'b0;

        // New packet after soft reset: header 08 -> 2 payload plus parity
        cyc(1'b1, 1'b0, 1'b1, 8'h08);
        cyc(1'b1, 1'b0, 1'b0, 8'hC1);
        cyc(1'b1, 1'b0, 1'b0, 8'hC2);
        cyc(1'b1, 1'b0, 1'b0, 8'hC3);
        cyc(1'b0, 1'b1, 1'b0, 8'h00); check("post_rd0", d_out, 9'h08);
        cyc(1'b0, 1'b1, 1'b0, 8'h00); check("post_rd1", d_out, 9'hC1);
        cyc(1'b0, 1'b1, 1'b0, 8'h00); check("post_rd2", d_out, 9'hC2);
        cyc(1'b0, 1'b0, 1'b0, 8'h00); check("post_hold", d_out, 9'hC2);
        cyc(1'b0, 1'b1, 1'b0, 8'h00); check("post_rd3", d_out, 9'hC3);
        cyc(1'b0, 1'b0, 1'b0, 8'h00); check("post_idle", d_out, 0);
        check("post_empty", empty, 1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
